frogger_traffic: RTL and testbench

- Producer of the car positions that the frog collision detector consumes: owns and advances the five cars, one per road lane.
- Each car moves horizontally at its own lane speed and wraps at the playfield edge.
- The rising edge of the collision signal freezes traffic for a fixed pause; all cars then reload to their start columns and traffic resumes.
- Sits between the game tick and both the collision detector and the sprite renderer.

---
 rtl/frogger_traffic_pkg.sv | 23 ++
 rtl/frogger_lane.sv | 83 ++++++++
 rtl/frogger_traffic.sv | 151 +++++++++++++++
 tb/tb_frogger_traffic.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_traffic_pkg.sv
// rtl/frogger_traffic_pkg.sv - shared playfield constants, lane tables and FSM encoding for frogger traffic
package frogger_traffic_pkg;

   typedef enum logic [1:0] {
      s_RUN    = 2'd0,
      s_FREEZE = 2'd1,
      s_RELOAD = 2'd2
   } state_t;

   localparam int c_GAME_WIDTH       = 14;
   localparam int c_NUM_LANES        = 5;
   localparam int c_TICK_CYCLES_DEF  = 1250000;
   localparam int c_FREEZE_TICKS_DEF = 20;

   // Lane tables: element [n-1] belongs to lane n (lane 1 is the rightmost field).
   localparam logic [4:0][5:0] c_LANE_PERIOD = {6'd5, 6'd3, 6'd4, 6'd3, 6'd2};
   localparam logic [4:0][5:0] c_LANE_Y      = {6'd11, 6'd10, 6'd9, 6'd8, 6'd7};
   localparam logic [4:0][5:0] c_LANE_X0     = {6'd8, 6'd3, 6'd10, 6'd5, 6'd0};

   // Bit n-1 belongs to lane n; a set bit marks a lane whose car travels toward column 0.
   localparam logic [4:0] c_LANE_DIR = 5'b01010;

endpackage

// File: rtl/frogger_lane.sv
// rtl/frogger_lane.sv - one traffic lane: step counter, effective period, wrapping X register (FROGGER_TRAFFIC_SPEEDUP_EN)
module frogger_lane
   import frogger_traffic_pkg::*;
#(
   parameter int         c_WIDTH  = c_GAME_WIDTH,
   parameter logic       c_LEFT   = 1'b0,
   parameter logic [5:0] c_X0     = 6'd0,
   parameter logic [5:0] c_PERIOD = 6'd1
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Tick_En,
   input  logic       i_Reload,
   input  logic [2:0] i_Level,
   output logic [5:0] o_X,
   output logic       o_Stepped
);

   localparam logic [5:0] c_LAST = 6'(c_WIDTH - 1);

   logic [5:0] lane_cnt;
   logic [5:0] eff_period;
   logic [5:0] next_x;

`ifdef FROGGER_TRAFFIC_SPEEDUP_EN
   // Higher levels shorten the period; saturate at zero, then clamp to one tick.
   always_comb begin
      eff_period = 6'd0;
      if (c_PERIOD > {3'b000, i_Level}) begin
         eff_period = c_PERIOD - {3'b000, i_Level};
      end
      if (eff_period == 6'd0) begin
         eff_period = 6'd1;
      end
   end
`else
   logic unused_level;
   assign unused_level = ^i_Level;

   // Level is ignored: the lane always runs at its base period.
   always_comb begin
      eff_period = c_PERIOD;
      if (c_PERIOD == 6'd0) begin
         eff_period = 6'd1;
      end
   end
`endif

   // Next column one tile along the lane direction, wrapping at the playfield edge.
   always_comb begin
      next_x = o_X;
      if (c_LEFT) begin
         next_x = (o_X == 6'd0) ? c_LAST : o_X - 6'd1;
      end else begin
         next_x = (o_X == c_LAST) ? 6'd0 : o_X + 6'd1;
      end
   end

   // Counter, position and step flag; reload wins over a tick.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         lane_cnt  <= 6'd0;
         o_X       <= c_X0;
         o_Stepped <= 1'b0;
      end else if (i_Reload) begin
         lane_cnt  <= 6'd0;
         o_X       <= c_X0;
         o_Stepped <= 1'b0;
      end else if (i_Tick_En) begin
         if (lane_cnt >= eff_period - 6'd1) begin
            lane_cnt  <= 6'd0;
            o_X       <= next_x;
            o_Stepped <= 1'b1;
         end else begin
            lane_cnt  <= lane_cnt + 6'd1;
            o_Stepped <= 1'b0;
         end
      end else begin
         o_Stepped <= 1'b0;
      end
   end

endmodule

// File: rtl/frogger_traffic.sv
// rtl/frogger_traffic.sv - five-lane car traffic with tick prescaler and collision freeze FSM (FROGGER_TRAFFIC_SPEEDUP_EN)
module frogger_traffic
   import frogger_traffic_pkg::*;
#(
   parameter int c_TICK_CYCLES  = c_TICK_CYCLES_DEF,
   parameter int c_FREEZE_TICKS = c_FREEZE_TICKS_DEF
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Collided,
   input  logic       i_Restart,
   input  logic [2:0] i_Level,
   output logic [5:0] o_Car_X_1,
   output logic [5:0] o_Car_X_2,
   output logic [5:0] o_Car_X_3,
   output logic [5:0] o_Car_X_4,
   output logic [5:0] o_Car_X_5,
   output logic [5:0] o_Car_Y_1,
   output logic [5:0] o_Car_Y_2,
   output logic [5:0] o_Car_Y_3,
   output logic [5:0] o_Car_Y_4,
   output logic [5:0] o_Car_Y_5,
   output logic       o_Frozen,
   output logic       o_Step
);

   localparam int PW = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
   localparam int FW = (c_FREEZE_TICKS > 1) ? $clog2(c_FREEZE_TICKS) : 1;
   localparam logic [PW-1:0] c_PRE_LAST = PW'(c_TICK_CYCLES - 1);
   localparam logic [FW-1:0] c_FRZ_LAST = FW'(c_FREEZE_TICKS - 1);

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   pre_cnt;
   logic [FW-1:0]   frz_cnt;
   logic            tick;
   logic            col_q;
   logic            col_edge;
   logic            lane_run;
   logic            lane_reload;
   logic            lane_tick;
   logic [4:0][5:0] lane_x;
   logic [4:0]      lane_stepped;

   assign tick      = (pre_cnt == c_PRE_LAST);
   assign col_edge  = i_Collided & ~col_q;
   assign lane_tick = tick & lane_run;

   // Free-running game-tick prescaler.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Previous collision level, so only a fresh rising edge can freeze traffic.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         col_q <= 1'b0;
      end else begin
         col_q <= i_Collided;
      end
   end

   // Freeze counter: held at zero outside the freeze, counts ticks inside it.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         frz_cnt <= '0;
      end else if (state != s_FREEZE) begin
         frz_cnt <= '0;
      end else if (tick) begin
         frz_cnt <= frz_cnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state <= s_RUN;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state; restart outranks everything, including a collision edge.
   always_comb begin
      state_next = state;
      case (state)
         s_RUN: begin
            if (i_Restart) begin
               state_next = s_RELOAD;
            end else if (col_edge) begin
               state_next = s_FREEZE;
            end
         end
         s_FREEZE: begin
            if (i_Restart) begin
               state_next = s_RELOAD;
            end else if (tick && frz_cnt == c_FRZ_LAST) begin
               state_next = s_RELOAD;
            end
         end
         s_RELOAD: begin
            state_next = i_Restart ? s_RELOAD : s_RUN;
         end
         default: state_next = s_RUN;
      endcase
   end

   // FSM outputs; a step coinciding with a collision edge or restart is dropped.
   always_comb begin
      o_Frozen    = (state != s_RUN);
      lane_run    = (state == s_RUN) & ~col_edge & ~i_Restart;
      lane_reload = (state == s_RELOAD);
   end

   genvar g;
   for (g = 0; g < c_NUM_LANES; g++) begin : g_lane
      frogger_lane #(
         .c_WIDTH  (c_GAME_WIDTH),
         .c_LEFT   (c_LANE_DIR[g]),
         .c_X0     (c_LANE_X0[g]),
         .c_PERIOD (c_LANE_PERIOD[g])
      ) u_lane (
         .i_Clk     (i_Clk),
         .i_Rst_L   (i_Rst_L),
         .i_Tick_En (lane_tick),
         .i_Reload  (lane_reload),
         .i_Level   (i_Level),
         .o_X       (lane_x[g]),
         .o_Stepped (lane_stepped[g])
      );
   end

   assign o_Step    = |lane_stepped;
   assign o_Car_X_1 = lane_x[0];
   assign o_Car_X_2 = lane_x[1];
   assign o_Car_X_3 = lane_x[2];
   assign o_Car_X_4 = lane_x[3];
   assign o_Car_X_5 = lane_x[4];
   assign o_Car_Y_1 = c_LANE_Y[0];
   assign o_Car_Y_2 = c_LANE_Y[1];
   assign o_Car_Y_3 = c_LANE_Y[2];
   assign o_Car_Y_4 = c_LANE_Y[3];
   assign o_Car_Y_5 = c_LANE_Y[4];

endmodule

// File: tb/tb_frogger_traffic.sv
// tb/tb_frogger_traffic.sv - randomized scoreboard bench for frogger_traffic against a behavioural traffic model
module tb_frogger_traffic;

   localparam int T = 4;
   localparam int F = 3;
   localparam int W = 14;

   int lane_period [5] = '{2, 3, 4, 3, 5};
   int lane_left   [5] = '{0, 1, 0, 1, 0};
   int lane_x0     [5] = '{0, 5, 10, 3, 8};
   int lane_y      [5] = '{7, 8, 9, 10, 11};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       col = 1'b0;
   logic       restart = 1'b0;
   logic [2:0] level = 3'd0;
   logic [5:0] cx1, cx2, cx3, cx4, cx5, cy1, cy2, cy3, cy4, cy5;
   logic       frozen, step;

   frogger_traffic #(.c_TICK_CYCLES(T), .c_FREEZE_TICKS(F)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Collided(col), .i_Restart(restart), .i_Level(level),
      .o_Car_X_1(cx1), .o_Car_X_2(cx2), .o_Car_X_3(cx3), .o_Car_X_4(cx4), .o_Car_X_5(cx5),
      .o_Car_Y_1(cy1), .o_Car_Y_2(cy2), .o_Car_Y_3(cy3), .o_Car_Y_4(cy4), .o_Car_Y_5(cy5),
      .o_Frozen(frozen), .o_Step(step)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0][5:0] x;
      logic            frozen;
      logic            step;
   } snap_t;

   snap_t q[$];
   int tests = 0;
   int fails = 0;
   int m_steps = 0;
   int d_steps = 0;

   // Behavioural model: mode 0 running, 1 frozen, 2 reloading
   int m_mode, m_pre, m_frz, m_prev_col;
   int m_x [5];
   int m_wait [5];

   task automatic m_reset();
      m_mode = 0; m_pre = 0; m_frz = 0; m_prev_col = 0;
      for (int n = 0; n < 5; n++) begin
         m_x[n] = lane_x0[n];
         m_wait[n] = 0;
      end
   endtask

   function automatic int eff_of(int n, int lvl);
      int e;
`ifdef FROGGER_TRAFFIC_SPEEDUP_EN
      e = lane_period[n] - lvl;
`else
      e = lane_period[n];
`endif
      if (e < 1) e = 1;
      return e;
   endfunction

   task automatic m_push(bit stepped);
      snap_t s;
      for (int n = 0; n < 5; n++) s.x[n] = 6'(m_x[n]);
      s.frozen = (m_mode != 0);
      s.step = stepped;
      q.push_back(s);
      if (stepped) m_steps++;
   endtask

   task automatic m_cycle();
      bit tick, edge_seen, moved;
      tick = (m_pre == T - 1);
      edge_seen = (col == 1'b1) && (m_prev_col == 0);
      moved = 0;
      if (m_mode == 2) begin
         for (int n = 0; n < 5; n++) begin
            m_x[n] = lane_x0[n];
            m_wait[n] = 0;
         end
         m_mode = restart ? 2 : 0;
      end else if (restart) begin
         m_mode = 2;
      end else if (m_mode == 0) begin
         if (edge_seen) begin
            m_mode = 1;
            m_frz = 0;
         end else if (tick) begin
            for (int n = 0; n < 5; n++) begin
               m_wait[n]++;
               if (m_wait[n] >= eff_of(n, int'(level))) begin
                  m_wait[n] = 0;
                  m_x[n] = lane_left[n] ? (m_x[n] + W - 1) % W : (m_x[n] + 1) % W;
                  moved = 1;
               end
            end
         end
      end else if (tick) begin
         if (m_frz == F - 1) m_mode = 2;
         else m_frz++;
      end
      m_pre = (m_pre + 1) % T;
      m_prev_col = int'(col);
      m_push(moved);
   endtask

   // Model follows the asynchronous reset immediately
   always @(negedge rst_n) m_reset();

   // Model advances on each clock edge and queues the expected outputs
   always @(posedge clk) begin
      if (!rst_n) begin
         m_reset();
         m_push(1'b0);
      end else begin
         m_cycle();
      end
   end

   // Monitor: pops one expectation per cycle and compares the DUT outputs
   always @(posedge clk) begin
      snap_t e, g;
      #1;
      g.x = {cx5, cx4, cx3, cx2, cx1};
      g.frozen = frozen;
      g.step = step;
      if (step) d_steps++;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL sb_empty t=%0t no expectation queued", $time);
      end else begin
         e = q.pop_front();
         if (g != e) begin
            fails++;
            $display("FAIL sb_cycle t=%0t got x=%h fr=%b st=%b exp x=%h fr=%b st=%b",
                     $time, g.x, g.frozen, g.step, e.x, e.frozen, e.step);
         end
      end
      tests++;
      if ({cy5, cy4, cy3, cy2, cy1} != {6'(lane_y[4]), 6'(lane_y[3]), 6'(lane_y[2]), 6'(lane_y[1]), 6'(lane_y[0])}) begin
         fails++;
         $display("FAIL car_y t=%0t got %h", $time, {cy5, cy4, cy3, cy2, cy1});
      end
   end

   task automatic check(string name, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic cycles(int n);
      for (int i = 0; i < n; i++) @(posedge clk);
   endtask

   task automatic check_x0(string name);
      check({name, "_x1"}, int'(cx1), lane_x0[0]);
      check({name, "_x2"}, int'(cx2), lane_x0[1]);
      check({name, "_x3"}, int'(cx3), lane_x0[2]);
      check({name, "_x4"}, int'(cx4), lane_x0[3]);
      check({name, "_x5"}, int'(cx5), lane_x0[4]);
   endtask

   initial begin
      int ms0, ds0;
      // Reset state
      cycles(3);
      #1;
      check_x0("reset");
      check("reset_frozen", int'(frozen), 0);
      check("reset_step", int'(step), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // First steps from the start columns
      cycles(8); #1;
      check("tick2_car1", int'(cx1), 1);
      cycles(4); #1;
      check("tick3_car2", int'(cx2), 4);
      check("tick3_car4", int'(cx4), 2);

      // Long run at level 0 exercises both wrap directions
      cycles(2 * 13 * T + 20);

      // Collision edge: freeze, hold, reload, no refreeze while held
      @(negedge clk); col = 1'b1;
      @(posedge clk); #1;
      check("col_frozen", int'(frozen), 1);
      cycles(T * F + T + 4); #1;
      check("col_released", int'(frozen), 0);
      cycles(3 * T); #1;
      check("col_held_no_refreeze", int'(frozen), 0);
      @(negedge clk); col = 1'b0;

      // Fastest level: one step per tick
      level = 3'd7;
      cycles(6);
      @(negedge clk);
      ms0 = m_steps; ds0 = d_steps;
      cycles(5 * T);
      @(negedge clk);
      check("level7_steps", d_steps - ds0, m_steps - ms0);
      check("level7_steps_nonzero", int'((d_steps - ds0) > 0), 1);

      // Restart and collision together: reload, no freeze
      level = 3'd0;
      @(negedge clk); restart = 1'b1; col = 1'b1;
      @(posedge clk); #1;
      check("restart_reload_frozen", int'(frozen), 1);
      @(negedge clk); restart = 1'b0;
      @(posedge clk); #1;
      check("restart_run", int'(frozen), 0);
      check_x0("restart");
      cycles(2 * T); #1;
      check("restart_no_freeze", int'(frozen), 0);
      @(negedge clk); col = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         restart = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 39) == 0) col = ~col;
         if ($urandom_range(0, 59) == 0) level = 3'($urandom_range(0, 7));
      end
      @(negedge clk); restart = 1'b0; col = 1'b0; level = 3'd0;
      cycles(T * F + 2 * T);

      // Asynchronous reset in the middle of a freeze
      @(negedge clk); col = 1'b1;
      cycles(2);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_x0("async_reset");
      check("async_reset_frozen", int'(frozen), 0);
      check("async_reset_step", int'(step), 0);
      cycles(2);
      @(negedge clk); rst_n = 1'b1; col = 1'b0;
      cycles(10 * T);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
